game_flow_ctrl: RTL and testbench

GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

---
 rtl/game_pkg.sv | 67 ++++++
 rtl/bcd_score_acc.sv | 57 +++++
 rtl/game_flow_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_game_flow_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types for the game flow controller: FSM state encoding, BCD digit
// type, sound-event bit positions, screen-message bundle and small helpers.
package game_pkg;

    typedef enum logic [2:0] {
        ST_START     = 3'd0,
        ST_PLAY      = 3'd1,
        ST_DYING     = 3'd2,
        ST_LEVEL_UP  = 3'd3,
        ST_GAME_OVER = 3'd4,
        ST_WIN       = 3'd5
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    // Bit positions inside the one-hot sound-event output
    localparam int SND_KILL  = 0;
    localparam int SND_HIT   = 1;
    localparam int SND_LEVEL = 2;
    localparam int SND_END   = 3;

    // Screen message selects plus player enable, registered as one bundle
    typedef struct packed {
        logic stg;
        logic scr;
        logic edg;
        logic win;
        logic plr;
    } msg_t;

    // Points for one cycle (0..198) split into a hundreds flag and two BCD digits
    typedef struct packed {
        logic       hund;
        bcd_digit_t tens;
        bcd_digit_t ones;
    } pts_bcd_t;

    // Message bundle shown while the FSM sits in a given state
    function automatic msg_t msgs_for(input state_t s);
        msg_t m;
        m = '0;
        case (s)
            ST_START:              m.stg = 1'b1;
            ST_PLAY: begin
                m.scr = 1'b1;
                m.plr = 1'b1;
            end
            ST_DYING, ST_LEVEL_UP: m.scr = 1'b1;
            ST_GAME_OVER:          m.edg = 1'b1;
            ST_WIN:                m.win = 1'b1;
            default:               m = '0;
        endcase
        return m;
    endfunction

    // Binary points value to BCD; both kill values are <= 99 so the sum is <= 198
    function automatic pts_bcd_t pts_to_bcd(input logic [7:0] v);
        pts_bcd_t   r;
        logic [7:0] rem;
        r.hund = (v >= 8'd100);
        rem    = r.hund ? (v - 8'd100) : v;
        r.tens = 4'(rem / 8'd10);
        r.ones = 4'(rem % 8'd10);
        return r;
    endfunction

endpackage

// File: rtl/bcd_score_acc.sv
// Four-digit BCD score accumulator with saturation at 9999.
// Adds a two-digit BCD addend (plus an optional hundreds carry-in, used when
// an invader and Lrrr kill land in the same cycle) on each add strobe.
module bcd_score_acc
    import game_pkg::*;
(
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 clr,
    input  logic                 add_en,
    input  bcd_digit_t [1:0]     add_val,
    input  logic                 add_hund,
    output bcd_digit_t [3:0]     score
);

    bcd_digit_t [3:0] score_reg;
    bcd_digit_t [3:0] sum_next;
    logic       [4:0] carry;

    assign carry[0] = 1'b0;

    // Ripple BCD adder, one decimal digit per generate slice
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
        bcd_digit_t addend;
        logic [4:0] raw;
        logic [4:0] raw_adj;

        if (gi < 2) begin : g_lo
            assign addend = add_val[gi];
        end else if (gi == 2) begin : g_hund
            assign addend = {3'b000, add_hund};
        end else begin : g_top
            assign addend = 4'd0;
        end

        assign raw          = {1'b0, score_reg[gi]} + {1'b0, addend} + {4'b0000, carry[gi]};
        assign raw_adj      = raw - 5'd10;
        assign carry[gi+1]  = (raw > 5'd9);
        assign sum_next[gi] = carry[gi+1] ? raw_adj[3:0] : raw[3:0];
    end

    // Score register: clear on reset or new game, saturate on carry out of the top digit
    always_ff @(posedge clk) begin
        if (!resetN || clr) begin
            score_reg <= '0;
        end else if (add_en) begin
            if (carry[4]) begin
                score_reg <= {4'd9, 4'd9, 4'd9, 4'd9};
            end else begin
                score_reg <= sum_next;
            end
        end
    end

    assign score = score_reg;

endmodule

// File: rtl/game_flow_ctrl.sv
// Game flow controller: start screen, play, respawn delay, level-up delay,
// game over and win, with lives/level/invader bookkeeping and BCD score.
// Optional build macro GAME_CHEAT_EN: when defined, cheatput forces WIN from
// PLAY, DYING or LEVEL_UP; when undefined cheatput is ignored.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int NUM_INV     = 128,
    parameter int LIVES       = 3,
    parameter int MAX_LEVEL   = 4,
    parameter int INV_PTS     = 10,
    parameter int LRR_PTS     = 50,
    parameter int RESPAWN_SEC = 2,
    parameter int LEVEL_SEC   = 3
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             spcKey,
    input  logic             oneSec,
    input  logic             plrHit,
    input  logic             invKill,
    input  logic             lrrKill,
    input  logic             invLand,
    input  logic             cheatput,
    output logic             stgMsg,
    output logic             scrMsg,
    output logic             edgMsg,
    output logic             winMsg,
    output logic             plrEn,
    output logic             waveRst,
    output logic [3:0][3:0]  scrNum,
    output logic [2:0]       scrLiv,
    output logic [3:0]       level,
    output logic [3:0]       sndOut
);

    localparam int INV_W   = $clog2(NUM_INV + 1);
    localparam int SEC_MAX = (RESPAWN_SEC > LEVEL_SEC) ? RESPAWN_SEC : LEVEL_SEC;
    localparam int SEC_W   = (SEC_MAX < 2) ? 1 : $clog2(SEC_MAX + 1);

    state_t             state_reg;
    msg_t               msg_reg;
    logic               key_prev_reg;
    logic [2:0]         lives_reg;
    logic [3:0]         level_reg;
    logic [INV_W-1:0]   inv_left_reg;
    logic [SEC_W-1:0]   sec_cnt_reg;
    logic               wave_rst_reg;
    logic [3:0]         snd_reg;

    logic               press;
    logic               scoring;
    logic               inv_credit;
    logic               lrr_credit;
    logic [INV_W-1:0]   inv_left_after;
    logic [2:0]         lives_after;
    logic [7:0]         pts_bin;
    pts_bcd_t           pts_bcd;
    logic               cheat;
    logic               score_clr;

`ifdef GAME_CHEAT_EN
    assign cheat = cheatput;
`else
    logic unused_cheat;
    assign unused_cheat = cheatput;
    assign cheat        = 1'b0;
`endif

    // Kills score while the wave is live, including during the respawn delay;
    // an invader kill with nothing left on screen is dropped.
    assign press          = spcKey & ~key_prev_reg;
    assign scoring        = (state_reg == ST_PLAY) || (state_reg == ST_DYING);
    assign inv_credit     = scoring & invKill & (inv_left_reg != '0);
    assign lrr_credit     = scoring & lrrKill;
    assign inv_left_after = inv_left_reg - {{(INV_W-1){1'b0}}, inv_credit};
    assign lives_after    = lives_reg - {2'b00, plrHit};
    assign pts_bin        = (inv_credit ? 8'(INV_PTS) : 8'd0) + (lrr_credit ? 8'(LRR_PTS) : 8'd0);
    assign pts_bcd        = pts_to_bcd(pts_bin);
    assign score_clr      = (state_reg == ST_START) && press;

    bcd_score_acc u_score (
        .clk      (clk),
        .resetN   (resetN),
        .clr      (score_clr),
        .add_en   (inv_credit | lrr_credit),
        .add_val  ({pts_bcd.tens, pts_bcd.ones}),
        .add_hund (pts_bcd.hund),
        .score    (scrNum)
    );

    // Game FSM with registered messages, pulses and game bookkeeping
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_reg    <= ST_START;
            msg_reg      <= msgs_for(ST_START);
            key_prev_reg <= 1'b1;
            lives_reg    <= 3'(LIVES);
            level_reg    <= 4'd1;
            inv_left_reg <= INV_W'(NUM_INV);
            sec_cnt_reg  <= '0;
            wave_rst_reg <= 1'b0;
            snd_reg      <= '0;
        end else begin
            key_prev_reg           <= spcKey;
            wave_rst_reg           <= 1'b0;
            snd_reg                <= '0;
            snd_reg[SND_KILL]      <= inv_credit | lrr_credit;
            if (inv_credit) begin
                inv_left_reg <= inv_left_after;
            end

            case (state_reg)
                ST_START: begin
                    if (press) begin
                        lives_reg    <= 3'(LIVES);
                        level_reg    <= 4'd1;
                        inv_left_reg <= INV_W'(NUM_INV);
                        wave_rst_reg <= 1'b1;
                        state_reg    <= ST_PLAY;
                        msg_reg      <= msgs_for(ST_PLAY);
                        sec_cnt_reg  <= '0;
                    end
                end

                ST_PLAY: begin
                    if (plrHit) begin
                        lives_reg         <= lives_after;
                        snd_reg[SND_HIT]  <= 1'b1;
                    end
                    // Loss outranks wave clear, which outranks a survivable hit
                    if (invLand || (plrHit && (lives_after == 3'd0))) begin
                        if (invLand) begin
                            lives_reg <= 3'd0;
                        end
                        state_reg        <= ST_GAME_OVER;
                        msg_reg          <= msgs_for(ST_GAME_OVER);
                        sec_cnt_reg      <= '0;
                        snd_reg[SND_END] <= 1'b1;
                    end else if (cheat) begin
                        state_reg        <= ST_WIN;
                        msg_reg          <= msgs_for(ST_WIN);
                        sec_cnt_reg      <= '0;
                        snd_reg[SND_END] <= 1'b1;
                    end else if (inv_left_after == '0) begin
                        if (level_reg < 4'(MAX_LEVEL)) begin
                            state_reg          <= ST_LEVEL_UP;
                            msg_reg            <= msgs_for(ST_LEVEL_UP);
                            snd_reg[SND_LEVEL] <= 1'b1;
                        end else begin
                            state_reg          <= ST_WIN;
                            msg_reg            <= msgs_for(ST_WIN);
                            snd_reg[SND_END]   <= 1'b1;
                        end
                        sec_cnt_reg <= '0;
                    end else if (plrHit) begin
                        state_reg   <= ST_DYING;
                        msg_reg     <= msgs_for(ST_DYING);
                        sec_cnt_reg <= '0;
                    end
                end

                ST_DYING: begin
                    if (cheat) begin
                        state_reg        <= ST_WIN;
                        msg_reg          <= msgs_for(ST_WIN);
                        sec_cnt_reg      <= '0;
                        snd_reg[SND_END] <= 1'b1;
                    end else if (oneSec) begin
                        if (sec_cnt_reg == SEC_W'(RESPAWN_SEC - 1)) begin
                            state_reg   <= ST_PLAY;
                            msg_reg     <= msgs_for(ST_PLAY);
                            sec_cnt_reg <= '0;
                        end else begin
                            sec_cnt_reg <= sec_cnt_reg + 1'b1;
                        end
                    end
                end

                ST_LEVEL_UP: begin
                    if (cheat) begin
                        state_reg        <= ST_WIN;
                        msg_reg          <= msgs_for(ST_WIN);
                        sec_cnt_reg      <= '0;
                        snd_reg[SND_END] <= 1'b1;
                    end else if (oneSec) begin
                        if (sec_cnt_reg == SEC_W'(LEVEL_SEC - 1)) begin
                            level_reg    <= level_reg + 4'd1;
                            inv_left_reg <= INV_W'(NUM_INV);
                            wave_rst_reg <= 1'b1;
                            state_reg    <= ST_PLAY;
                            msg_reg      <= msgs_for(ST_PLAY);
                            sec_cnt_reg  <= '0;
                        end else begin
                            sec_cnt_reg <= sec_cnt_reg + 1'b1;
                        end
                    end
                end

                ST_GAME_OVER, ST_WIN: begin
                    if (press) begin
                        state_reg   <= ST_START;
                        msg_reg     <= msgs_for(ST_START);
                        sec_cnt_reg <= '0;
                    end
                end

                default: begin
                    state_reg   <= ST_START;
                    msg_reg     <= msgs_for(ST_START);
                    sec_cnt_reg <= '0;
                end
            endcase
        end
    end

    assign stgMsg  = msg_reg.stg;
    assign scrMsg  = msg_reg.scr;
    assign edgMsg  = msg_reg.edg;
    assign winMsg  = msg_reg.win;
    assign plrEn   = msg_reg.plr;
    assign waveRst = wave_rst_reg;
    assign scrLiv  = lives_reg;
    assign level   = level_reg;
    assign sndOut  = snd_reg;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scoreboard bench for game_flow_ctrl: stimulus pushes expected snapshots,
// a negedge monitor pops one whenever the DUT pulses waveRst/sndOut or the
// stimulus requests a probe of the current outputs.
module tb_game_flow_ctrl;

    logic             clk = 1'b0;
    logic             resetN, spcKey, oneSec, plrHit, invKill, lrrKill, invLand, cheatput;
    logic             stgMsg, scrMsg, edgMsg, winMsg, plrEn, waveRst;
    logic [3:0][3:0]  scrNum;
    logic [2:0]       scrLiv;
    logic [3:0]       level;
    logic [3:0]       sndOut;

    logic             probe = 1'b0;
    logic             end_check = 1'b0;
    int               n_tests = 0;
    int               n_fail  = 0;

    int               m_score, m_lives, m_level;

    // stg, scr, edg, win, plrEn
    localparam logic [4:0] M_START = 5'b10000;
    localparam logic [4:0] M_PLAY  = 5'b01001;
    localparam logic [4:0] M_DYING = 5'b01000;
    localparam logic [4:0] M_LVL   = 5'b01000;
    localparam logic [4:0] M_OVER  = 5'b00100;
    localparam logic [4:0] M_WIN   = 5'b00010;

    typedef struct {
        string       name;
        logic        wave;
        logic [3:0]  snd;
        logic [4:0]  msgs;
        logic [15:0] score;
        logic [2:0]  lives;
        logic [3:0]  level;
    } exp_t;

    exp_t sb_q[$];

    game_flow_ctrl dut (
        .clk      (clk),
        .resetN   (resetN),
        .spcKey   (spcKey),
        .oneSec   (oneSec),
        .plrHit   (plrHit),
        .invKill  (invKill),
        .lrrKill  (lrrKill),
        .invLand  (invLand),
        .cheatput (cheatput),
        .stgMsg   (stgMsg),
        .scrMsg   (scrMsg),
        .edgMsg   (edgMsg),
        .winMsg   (winMsg),
        .plrEn    (plrEn),
        .waveRst  (waveRst),
        .scrNum   (scrNum),
        .scrLiv   (scrLiv),
        .level    (level),
        .sndOut   (sndOut)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int t;
        t = v;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic expect_ev(input string n, input logic w, input logic [3:0] s, input logic [4:0] m);
        exp_t e;
        e.name  = n;
        e.wave  = w;
        e.snd   = s;
        e.msgs  = m;
        e.score = to_bcd(m_score);
        e.lives = 3'(m_lives);
        e.level = 4'(m_level);
        sb_q.push_back(e);
    endtask

    task automatic add_pts(input int p);
        m_score = (m_score + p > 9999) ? 9999 : m_score + p;
    endtask

    task automatic step(input logic inv, input logic lrr, input logic hit,
                        input logic sec, input logic land, input logic cht);
        invKill  = inv;
        lrrKill  = lrr;
        plrHit   = hit;
        oneSec   = sec;
        invLand  = land;
        cheatput = cht;
        @(posedge clk);
        #1;
        invKill = 0; lrrKill = 0; plrHit = 0; oneSec = 0; invLand = 0; cheatput = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic probe_chk(input string n, input logic [4:0] m);
        @(posedge clk);
        #1;
        expect_ev(n, 1'b0, 4'b0000, m);
        probe = 1'b1;
        @(posedge clk);
        #1;
        probe = 1'b0;
    endtask

    task automatic press();
        spcKey = 1'b1;
        @(posedge clk);
        #1;
        spcKey = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic new_game();
        m_score = 0; m_lives = 3; m_level = 1;
        expect_ev("start_press", 1'b1, 4'b0000, M_PLAY);
        press();
    endtask

    task automatic kill_run(input int n, input logic [3:0] last_snd, input logic [4:0] last_msg,
                            input logic last_sec);
        for (int i = 1; i <= n; i++) begin
            add_pts(10);
            if (i == n) begin
                expect_ev("inv_kill_last", 1'b0, last_snd, last_msg);
                step(1, 0, 0, last_sec, 0, 0);
            end else begin
                expect_ev("inv_kill", 1'b0, 4'b0001, M_PLAY);
                step(1, 0, 0, 0, 0, 0);
            end
        end
    endtask

    task automatic wave_advance();
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        probe_chk("level_wait", M_LVL);
        m_level = m_level + 1;
        expect_ev("level_next", 1'b1, 4'b0000, M_PLAY);
        step(0, 0, 0, 1, 0, 0);
    endtask

    task automatic respawn();
        step(0, 0, 0, 1, 0, 0);
        probe_chk("dying_wait", M_DYING);
        step(0, 0, 0, 1, 0, 0);
        probe_chk("respawned", M_PLAY);
    endtask

    // Monitor: pop and compare whenever the DUT pulses or a probe is requested
    always @(negedge clk) begin : monitor
        exp_t e;
        logic [4:0] act_msg;
        act_msg = {stgMsg, scrMsg, edgMsg, winMsg, plrEn};
        if (end_check) begin
            n_tests++;
            if (sb_q.size() != 0) begin
                n_fail++;
                $display("FAIL leftover: got %0d pending expectations (next %s), want 0",
                         sb_q.size(), sb_q[0].name);
            end
        end else if (waveRst || (sndOut != 4'b0000) || probe) begin
            n_tests++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event: got wave=%0b snd=%b msg=%b score=%h, want no event",
                         waveRst, sndOut, act_msg, scrNum);
            end else begin
                e = sb_q.pop_front();
                if (waveRst !== e.wave || sndOut !== e.snd || act_msg !== e.msgs ||
                    scrNum !== e.score || scrLiv !== e.lives || level !== e.level) begin
                    n_fail++;
                    $display("FAIL %s: got wave=%0b snd=%b msg=%b score=%h lives=%0d level=%0d, want wave=%0b snd=%b msg=%b score=%h lives=%0d level=%0d",
                             e.name, waveRst, sndOut, act_msg, scrNum, scrLiv, level,
                             e.wave, e.snd, e.msgs, e.score, e.lives, e.level);
                end else begin
                    $display("[TB] ok %s score=%h lives=%0d level=%0d", e.name, scrNum, scrLiv, level);
                end
            end
        end
    end

    // Watchdog: the directed run is far shorter than this
    initial begin
        #400000;
        $display("FAIL watchdog: got no finish within time limit, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetN = 0; spcKey = 1; oneSec = 0; plrHit = 0; invKill = 0;
        lrrKill = 0; invLand = 0; cheatput = 0;
        m_score = 0; m_lives = 3; m_level = 1;

        // Reset with the key held, then key must not start the game until re-pressed
        idle(2);
        probe_chk("reset_state", M_START);
        resetN = 1;
        idle(3);
        probe_chk("held_key", M_START);
        spcKey = 0;
        idle(2);
        probe_chk("key_released", M_START);
        new_game();

        // Full wave at level 1; oneSec on the clearing kill must not count
        kill_run(128, 4'b0101, M_LVL, 1'b1);
        wave_advance();

        // Three hits with respawns, a Lrrr kill scored while dying
        m_lives = 2;
        expect_ev("hit1", 1'b0, 4'b0010, M_DYING);
        step(0, 0, 1, 0, 0, 0);
        add_pts(50);
        expect_ev("dying_lrr", 1'b0, 4'b0001, M_DYING);
        step(0, 1, 0, 0, 0, 0);
        respawn();
        m_lives = 1;
        expect_ev("hit2", 1'b0, 4'b0010, M_DYING);
        step(0, 0, 1, 0, 0, 0);
        respawn();
        m_lives = 0;
        expect_ev("hit3_over", 1'b0, 4'b1010, M_OVER);
        step(0, 0, 1, 0, 0, 0);
        idle(3);
        probe_chk("over_hold", M_OVER);
        press();
        probe_chk("back_to_start", M_START);
        new_game();

        // Last invader and a hit in the same cycle with two lives
        m_lives = 2;
        expect_ev("hit_to_two", 1'b0, 4'b0010, M_DYING);
        step(0, 0, 1, 0, 0, 0);
        respawn();
        kill_run(127, 4'b0001, M_PLAY, 1'b0);
        add_pts(10);
        m_lives = 1;
        expect_ev("kill_and_hit", 1'b0, 4'b0111, M_LVL);
        step(1, 0, 1, 0, 0, 0);
        wave_advance();

        // Build score to 9990, then saturate at 9999
        for (int i = 0; i < 174; i++) begin
            add_pts(50);
            expect_ev("lrr_kill", 1'b0, 4'b0001, M_PLAY);
            step(0, 1, 0, 0, 0, 0);
        end
        add_pts(10);
        expect_ev("score_9990", 1'b0, 4'b0001, M_PLAY);
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            add_pts(50);
            expect_ev("score_sat", 1'b0, 4'b0001, M_PLAY);
            step(0, 1, 0, 0, 0, 0);
        end

        // Clear the remaining waves through MAX_LEVEL to reach WIN
        kill_run(127, 4'b0101, M_LVL, 1'b0);
        wave_advance();
        kill_run(128, 4'b0101, M_LVL, 1'b0);
        wave_advance();
        kill_run(128, 4'b1001, M_WIN, 1'b0);
        idle(3);
        probe_chk("win_hold", M_WIN);
        press();
        probe_chk("win_to_start", M_START);

        // Invaders landing end the game regardless of lives
        new_game();
        kill_run(3, 4'b0001, M_PLAY, 1'b0);
        m_lives = 0;
        expect_ev("inv_land", 1'b0, 4'b1000, M_OVER);
        step(0, 0, 0, 0, 1, 0);
        press();
        probe_chk("land_to_start", M_START);

        // Cheat request in PLAY
        new_game();
        kill_run(2, 4'b0001, M_PLAY, 1'b0);
`ifdef GAME_CHEAT_EN
        expect_ev("cheat_win", 1'b0, 4'b1000, M_WIN);
        step(0, 0, 0, 0, 0, 1);
        probe_chk("cheat_hold", M_WIN);
`else
        step(0, 0, 0, 0, 0, 1);
        probe_chk("cheat_ignored", M_PLAY);
`endif

        // Mid-game reset returns everything to start values
        resetN = 0;
        m_score = 0; m_lives = 3; m_level = 1;
        idle(1);
        probe_chk("mid_reset", M_START);
        resetN = 1;
        idle(2);

        end_check = 1'b1;
        @(posedge clk);
        #1;
        end_check = 1'b0;
        idle(1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
